// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   fetch_state_e    - fetch FSM state encodings (FETCH / HOLD / DISCARD)
//   fetch_entry_t    - instruction word paired with its PC+4, as held in the
//                      one-entry hold buffer
//   NOP_WORD_DEFAULT - instruction word used for pipeline bubbles
//   RESET_PC_DEFAULT - PC loaded on reset
//   pcIncr()         - sequential PC step, wrapping modulo 2^32
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } fetch_entry_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Plain 32-bit add: the carry out is dropped, so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pcIncr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register between two stages (used here as IF/ID).
// Ports:
//   Clk, Rst_n          - clock, asynchronous active-low reset
//   Clr                 - force a bubble; wins over a hold
//   En                  - load the inputs (0 = hold current contents)
//   InstrIn, PCPlus4In,
//   ValidIn             - next contents when En=1
//   InstrD, PCPlus4D,
//   ValidD              - registered contents seen by the next stage
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Clr,
  input  logic        En,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCPlus4In,
  input  logic        ValidIn,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // A clear must squash the slot even when the downstream stage is stalled,
  // otherwise a wrong-path instruction would survive a redirect.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      InstrD   <= NOP_WORD;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (Clr) begin
      InstrD   <= NOP_WORD;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (En) begin
      InstrD   <= InstrIn;
      PCPlus4D <= PCPlus4In;
      ValidD   <= ValidIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory request/ready handshake,
// parks a completed fetch in a one-entry buffer while fetch is stalled, and
// feeds the IF/ID register. A slow memory produces bubbles, never back-pressure.
// Ports:
//   Clk, Rst_n             - clock, asynchronous active-low reset
//   StallF, StallD         - hazard-unit stalls for fetch and IF/ID
//   PCSrcD, PCBranchD      - branch redirect from decode
//   IMemReq, IMemAddr      - fetch request and its (stable) address
//   IMemReady, IMemRData   - request completion and returned word
//   InstrD, PCPlus4D,
//   ValidD                 - IF/ID contents (ValidD=0 marks a bubble)
//   PCF                    - current fetch PC for debug/trace
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] PCF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  reqAddr_q, reqAddr_d;
  fetch_entry_t buf_q, buf_d;

  logic         redirect;
  logic         deliver;
  fetch_entry_t deliverEntry;

  // A branch resolved while decode is stalled may itself be on a stale path,
  // so it only takes effect once decode is free to move.
  assign redirect = PCSrcD & ~StallD;
  assign PCF      = pc_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      reqAddr_q <= RESET_PC;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqAddr_q <= reqAddr_d;
      buf_q     <= buf_d;
    end
  end

  // DISCARD exists because a request cannot be withdrawn: after a redirect
  // with the old fetch still outstanding, the old address is kept on the bus
  // until memory answers, and the answer is thrown away.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    reqAddr_d    = reqAddr_q;
    buf_d        = buf_q;
    IMemReq      = 1'b0;
    IMemAddr     = pc_q;
    deliver      = 1'b0;
    deliverEntry = '0;

    case (state_q)
      FETCH: begin
        IMemReq   = 1'b1;
        IMemAddr  = pc_q;
        reqAddr_d = pc_q;
        if (redirect) begin
          pc_d = PCBranchD;
          if (!IMemReady) begin
            state_d = DISCARD;
          end
        end else if (IMemReady) begin
          if (!StallF) begin
            deliver      = 1'b1;
            deliverEntry = '{instr: IMemRData, pcPlus4: pcIncr(pc_q)};
            pc_d         = pcIncr(pc_q);
          end else begin
            buf_d   = '{instr: IMemRData, pcPlus4: pcIncr(pc_q)};
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = PCBranchD;
          state_d = FETCH;
        end else if (!StallF) begin
          deliver      = 1'b1;
          deliverEntry = buf_q;
          pc_d         = pcIncr(pc_q);
          state_d      = FETCH;
        end
      end

      DISCARD: begin
        IMemReq  = 1'b1;
        IMemAddr = reqAddr_q;
        if (redirect) begin
          pc_d = PCBranchD;
        end
        if (IMemReady) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Clr      (redirect),
    .En       (~StallD),
    .InstrIn  (deliver ? deliverEntry.instr : NOP_WORD),
    .PCPlus4In(deliver ? deliverEntry.pcPlus4 : 32'h0),
    .ValidIn  (deliver),
    .InstrD   (InstrD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request/ready handshake, one-entry hold buffer, and the IF/ID pipeline register.
- Sits directly upstream of decode.
- Consumes StallF/StallD from the hazard unit and the branch redirect (PCSrcD/PCBranchD) from decode.
- Produces InstrD/PCPlus4D/ValidD, which feed the decode stage and, via RsD/RtD, the hazard unit.
- Inserts bubbles when instruction memory is slow, so fetch never back-pressures the rest of the pipe.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven into IF/ID for a bubble.

Ports:
- Clk, input, 1, pipeline clock; all state updates on the rising edge.
- Rst_n, input, 1, asynchronous active-low reset.
- StallF, input, 1, hold PCF and do not accept a new fetch result.
- StallD, input, 1, hold the IF/ID register.
- PCSrcD, input, 1, branch taken in decode.
- PCBranchD, input, 32, branch target.
- IMemReq, output, 1, fetch request valid.
- IMemAddr, output, 32, fetch address; stable while a request is outstanding.
- IMemReady, input, 1, request completes this cycle; IMemRData is valid.
- IMemRData, input, 32, instruction word.
- InstrD, output, 32, IF/ID instruction.
- PCPlus4D, output, 32, IF/ID PC+4.
- ValidD, output, 1, IF/ID holds a real instruction (0 = bubble).
- PCF, output, 32, current fetch PC, for debug and trace.

Behaviour:
- Clocking: one clock, Clk. Reset Rst_n is asynchronous, active-low.
- Reset values: PCF=RESET_PC; state=FETCH; InstrD=NOP_WORD; PCPlus4D=0; ValidD=0; hold buffer=0. IMemReq is 1 in the first cycle after release.
- Redirect: redirect = PCSrcD & ~StallD. A PCSrcD seen while StallD=1 is ignored.

States:
- FETCH:
  - IMemReq=1, IMemAddr=PCF; ReqAddr<=PCF every cycle.
  - IMemReady & ~StallF & ~redirect: deliver {IMemRData, PCF+4} to IF/ID; PCF<=PCF+4; stay in FETCH.
  - IMemReady & StallF & ~redirect: buffer<={IMemRData, PCF+4}; go to HOLD.
  - redirect & IMemReady: drop the data; PCF<=PCBranchD; stay in FETCH.
  - redirect & ~IMemReady: PCF<=PCBranchD; go to DISCARD.
- HOLD:
  - IMemReq=0.
  - ~StallF & ~redirect: deliver the buffer to IF/ID; PCF<=PCF+4; go to FETCH.
  - redirect: drop the buffer; PCF<=PCBranchD; go to FETCH.
- DISCARD:
  - IMemReq=1, IMemAddr=ReqAddr (old address held until the handshake completes).
  - IMemReady: go to FETCH; the word is never delivered.
  - A further redirect updates PCF only.

IF/ID update, priority order:
1. Reset.
2. redirect -> bubble (InstrD=NOP_WORD, ValidD=0, PCPlus4D=0).
3. StallD -> hold.
4. Delivery -> load, ValidD=1.
5. Otherwise -> bubble.

Timing and protocol:
- Zero-wait memory: the instruction reaches IF/ID one cycle after the request; throughput is 1 instruction/cycle.
- Every IMemReq/IMemReady handshake completes. IMemAddr never changes while IMemReq=1 and IMemReady=0.
- StallF=1 with StallD=0 is legal: the fetched word is buffered and IF/ID receives a bubble.
- Reset asserted mid-operation (any state): outputs take their reset values immediately; the outstanding request is abandoned.
- PC arithmetic is 32-bit and wraps modulo 2^32: 0xFFFF_FFFC+4 = 0.

Decomposition:
- Shared constants header: FSM state encodings (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2), NOP_WORD, RESET_PC default.
- One sub-module: if_id_reg.
  - Inputs: Clk, Rst_n, Clr, En, InstrIn, PCPlus4In, ValidIn.
  - Outputs: InstrD, PCPlus4D, ValidD.
  - Clr has priority over hold; the same module is reusable for the other pipeline registers.
- The FSM, PC register and hold buffer stay in fetch_stage.

Test Plan:
1. Release reset, IMemReady=1, IMemRData=addr^32'hA5A5_0000 -> IMemAddr runs 0x0,0x4,0x8; InstrD shows 0xA5A5_0000, then 0xA5A5_0004 one cycle later; ValidD=1 from cycle 2; PCPlus4D=0x4,0x8.
2. IMemReady low for 3 cycles during the fetch of 0x8 -> IMemAddr stays 0x8; ValidD=0 for 3 cycles; then InstrD=0xA5A5_0008, PCPlus4D=0xC.
3. StallF=StallD=1 for 2 cycles while fetching 0xC with IMemReady=1 -> state HOLD; IMemReq=0; IF/ID unchanged. After release, InstrD=0xA5A5_000C with no re-request of 0xC; the next IMemAddr is 0x10.
4. PCSrcD=1, PCBranchD=0x100 while 0x10 is outstanding with IMemReady=0 -> IMemAddr holds 0x10 until ready; that word is never shown (ValidD=0); the next request is 0x100; InstrD=0xA5A5_0100.
5. PCSrcD=1 with StallD=1 -> no redirect; PCF continues sequentially. PCSrcD=1 with StallD=0 and IMemReady=1 -> IF/ID bubble, next IMemAddr=PCBranchD.
6. Assert Rst_n low mid-HOLD (asynchronous, between edges) -> ValidD=0, InstrD=0, PCF=RESET_PC immediately. After release, a fresh request to RESET_PC follows.
